ndp_stream_ctrl: RTL and testbench

//  Parametrised next-gen NDP core controller. Accepts a valid/ready word stream of activation/weight layer

---
 rtl/ndp_stream_ctrl_pkg.sv | 21 ++
 rtl/ndp_wrap_counter.sv | 29 ++
 rtl/ndp_stream_ctrl.sv | 151 +++++++++++++++
 tb/tb_ndp_stream_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ndp_stream_ctrl_pkg.sv
// Shared types and helpers for the NDP stream controller.
package ndp_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_ACT  = 3'd1,
    ST_LOAD_WGT  = 3'd2,
    ST_FEED      = 3'd3,
    ST_WAIT_CALC = 3'd4,
    ST_DRAIN     = 3'd5
  } state_t;

  localparam logic SP_SEL_ACT = 1'b0;
  localparam logic SP_SEL_WGT = 1'b1;

  // Index width for a range of v entries, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/ndp_wrap_counter.sv
// Wrapping up-counter 0..MAX with synchronous clear and terminal-count flag.
module ndp_wrap_counter
  import ndp_stream_ctrl_pkg::*;
#(
  parameter int unsigned W   = 1,
  parameter int unsigned MAX = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         last_c
);

  assign last_c = (cnt == W'(MAX));

  // Count register: clear wins over enable, wrap to zero after MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last_c ? '0 : W'(cnt + W'(1));
    end
  end

endmodule

// File: rtl/ndp_stream_ctrl.sv
// Streams activation/weight layer groups into the scratch pad, feeds each
// filled batch to the NDP unit, then drains the result words.
module ndp_stream_ctrl
  import ndp_stream_ctrl_pkg::*;
#(
  parameter int unsigned BUS_W       = 32,
  parameter int unsigned ACT_WORDS   = 2,
  parameter int unsigned WGT_WORDS   = 128,
  parameter int unsigned BUFFER_SIZE = 5,
  parameter int unsigned OUT_WORDS   = 64,
  parameter int unsigned LYR_W       = clog2_min1(BUFFER_SIZE),
  parameter int unsigned WRD_W       = clog2_min1(WGT_WORDS),
  parameter int unsigned OUT_W       = clog2_min1(OUT_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             sp_we,
  output logic             sp_sel,
  output logic [LYR_W-1:0] sp_layer,
  output logic [WRD_W-1:0] sp_word,
  output logic [BUS_W-1:0] sp_wdata,
  output logic             feed_en,
  output logic [LYR_W-1:0] feed_layer,
  output logic             unit_in_done,
  input  logic             unit_calc_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_idx,
  output logic             done,
  output logic             busy,
  output logic             err_proto
);

  state_t state, state_next;

  logic             beat, act_en, wgt_en, last_wgt, close_batch;
  logic             feed_end, out_beat, out_final;
  logic             act_last_c, wgt_last_c, layer_last_c, feed_last_c, out_last_c;
  logic [WRD_W-1:0] act_cnt, wgt_cnt;
  logic [LYR_W-1:0] layer_cnt, feed_cnt, fill_m1;
  logic [OUT_W-1:0] out_cnt;
  logic             job_end;

  // Handshake qualifiers and batch/feed/drain terminal conditions.
  assign beat        = in_valid & in_ready;
  assign act_en      = beat & ((state == ST_IDLE) | (state == ST_LOAD_ACT));
  assign wgt_en      = beat & (state == ST_LOAD_WGT);
  assign last_wgt    = wgt_en & wgt_last_c;
  assign close_batch = last_wgt & (in_last | layer_last_c);
  assign feed_end    = (state == ST_FEED) & ((feed_cnt == fill_m1) | feed_last_c);
  assign out_beat    = out_valid & out_ready;
  assign out_final   = (state == ST_DRAIN) & out_beat & out_last_c;
  assign out_idx     = out_cnt;

  ndp_wrap_counter #(.W(WRD_W), .MAX(ACT_WORDS - 1)) u_act_cnt (
    .clk(clk), .reset(reset), .en(act_en), .clr(1'b0), .cnt(act_cnt), .last_c(act_last_c)
  );

  ndp_wrap_counter #(.W(WRD_W), .MAX(WGT_WORDS - 1)) u_wgt_cnt (
    .clk(clk), .reset(reset), .en(wgt_en), .clr(1'b0), .cnt(wgt_cnt), .last_c(wgt_last_c)
  );

  ndp_wrap_counter #(.W(LYR_W), .MAX(BUFFER_SIZE - 1)) u_layer_cnt (
    .clk(clk), .reset(reset), .en(last_wgt & ~close_batch), .clr(close_batch),
    .cnt(layer_cnt), .last_c(layer_last_c)
  );

  ndp_wrap_counter #(.W(LYR_W), .MAX(BUFFER_SIZE - 1)) u_feed_cnt (
    .clk(clk), .reset(reset), .en(state == ST_FEED), .clr(feed_end),
    .cnt(feed_cnt), .last_c(feed_last_c)
  );

  ndp_wrap_counter #(.W(OUT_W), .MAX(OUT_WORDS - 1)) u_out_cnt (
    .clk(clk), .reset(reset), .en((state == ST_DRAIN) & out_beat), .clr(1'b0),
    .cnt(out_cnt), .last_c(out_last_c)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:      if (beat) state_next = act_last_c ? ST_LOAD_WGT : ST_LOAD_ACT;
      ST_LOAD_ACT:  if (beat && act_last_c) state_next = ST_LOAD_WGT;
      ST_LOAD_WGT:  if (last_wgt) state_next = close_batch ? ST_FEED : ST_LOAD_ACT;
      ST_FEED:      if (feed_end) state_next = job_end ? ST_WAIT_CALC : ST_LOAD_ACT;
      ST_WAIT_CALC: if (unit_calc_done) state_next = ST_DRAIN;
      ST_DRAIN:     if (out_final) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Registered outputs and job bookkeeping; feed_en trails FEED by one
  // cycle so the last scratch-pad write lands before its layer is read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready     <= 1'b0;
      sp_we        <= 1'b0;
      sp_sel       <= SP_SEL_ACT;
      sp_layer     <= '0;
      sp_word      <= '0;
      sp_wdata     <= '0;
      feed_en      <= 1'b0;
      feed_layer   <= '0;
      unit_in_done <= 1'b0;
      out_valid    <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      err_proto    <= 1'b0;
      fill_m1      <= '0;
      job_end      <= 1'b0;
    end else begin
      sp_we <= beat;
      if (beat) begin
        sp_sel   <= (state == ST_LOAD_WGT) ? SP_SEL_WGT : SP_SEL_ACT;
        sp_layer <= layer_cnt;
        sp_word  <= (state == ST_LOAD_WGT) ? wgt_cnt : act_cnt;
        sp_wdata <= in_data;
      end
      if (last_wgt) fill_m1 <= layer_cnt;
      if (close_batch) begin
        job_end <= in_last;
      end else if (feed_end) begin
        job_end <= 1'b0;
      end
      if (beat && in_last && !last_wgt) err_proto <= 1'b1;
      feed_en      <= (state == ST_FEED);
      feed_layer   <= (state == ST_FEED) ? feed_cnt : '0;
      unit_in_done <= ((state_next == ST_WAIT_CALC) || (state_next == ST_DRAIN))
                      && (state != ST_FEED);
      out_valid    <= (state_next == ST_DRAIN);
      done         <= out_final;
      in_ready     <= (state_next == ST_IDLE) || (state_next == ST_LOAD_ACT)
                      || (state_next == ST_LOAD_WGT);
      busy         <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ndp_stream_ctrl.sv
// Randomised bench for ndp_stream_ctrl with a timestamp-based reference model.
module tb_ndp_stream_ctrl;

  localparam int BUS_W = 32;
  localparam int A     = 2;
  localparam int WG    = 4;
  localparam int B     = 3;
  localparam int O     = 4;
  localparam int LW    = 2;
  localparam int WW    = 2;
  localparam int OW    = 2;
  localparam int LB    = A + WG;
  localparam int INF   = 32'h3fff_ffff;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [BUS_W-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             sp_we, sp_sel;
  logic [LW-1:0]    sp_layer;
  logic [WW-1:0]    sp_word;
  logic [BUS_W-1:0] sp_wdata;
  logic             feed_en;
  logic [LW-1:0]    feed_layer;
  logic             unit_in_done;
  logic             unit_calc_done = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OW-1:0]    out_idx;
  logic             done, busy, err_proto;

  always #5 clk = ~clk;

  ndp_stream_ctrl #(
    .BUS_W(BUS_W), .ACT_WORDS(A), .WGT_WORDS(WG), .BUFFER_SIZE(B), .OUT_WORDS(O)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .sp_we(sp_we), .sp_sel(sp_sel), .sp_layer(sp_layer),
    .sp_word(sp_word), .sp_wdata(sp_wdata), .feed_en(feed_en), .feed_layer(feed_layer),
    .unit_in_done(unit_in_done), .unit_calc_done(unit_calc_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .done(done), .busy(busy), .err_proto(err_proto)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: job progress expressed as beat count plus event timestamps.
  int  k, ready_from, busy_from, busy_to, uid_from, wait_start, drain_start;
  int  obeats, err_from, feed_from, feed_to;
  bit  in_job, post_load, draining;
  bit              ew   [16];
  logic            esel [16];
  logic [LW-1:0]   elyr [16];
  logic [WW-1:0]   ewrd [16];
  logic [BUS_W-1:0] edat[16];

  // Job plan for the stimulus.
  bit plan_active;
  int plan_beats, illegal_at, gap_pct, stall_pct, cd_pct;

  // Observed DUT activity used by the literal pins.
  int          n_we, n_feed, n_done, n_ob;
  logic [31:0] sel_hist, feed_hist, idx_hist;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit exp_ready();
    return !post_load && (cyc >= ready_from);
  endfunction

  task automatic model_reset();
    k = 0; in_job = 0; post_load = 0; draining = 0; plan_active = 0;
    ready_from = cyc + 1; busy_from = INF; busy_to = -10; uid_from = INF;
    wait_start = INF; drain_start = INF; obeats = 0; err_from = INF;
    feed_from = INF; feed_to = -10;
    for (int i = 0; i < 16; i++) ew[i] = 1'b0;
  endtask

  task automatic clear_obs();
    n_we = 0; n_feed = 0; n_done = 0; n_ob = 0;
    sel_hist = '0; feed_hist = '0; idx_hist = '0;
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check_cycle();
    automatic int s = cyc % 16;
    automatic bit fe = (cyc >= feed_from) && (cyc <= feed_to);
    automatic bit ov = draining && (cyc >= drain_start);
    chk("in_ready", 32'(in_ready), 32'(exp_ready()));
    chk("busy", 32'(busy), 32'((cyc >= busy_from) && (cyc <= busy_to)));
    chk("sp_we", 32'(sp_we), 32'(ew[s]));
    if (ew[s]) begin
      chk("sp_sel", 32'(sp_sel), 32'(esel[s]));
      chk("sp_layer", 32'(sp_layer), 32'(elyr[s]));
      chk("sp_word", 32'(sp_word), 32'(ewrd[s]));
      chk("sp_wdata", sp_wdata, edat[s]);
    end
    ew[s] = 1'b0;
    chk("feed_en", 32'(feed_en), 32'(fe));
    if (fe) chk("feed_layer", 32'(feed_layer), 32'(cyc - feed_from));
    chk("unit_in_done", 32'(unit_in_done), 32'((cyc >= uid_from) && (cyc <= busy_to)));
    chk("out_valid", 32'(out_valid), 32'(ov));
    if (ov) chk("out_idx", 32'(out_idx), 32'(obeats));
    chk("done", 32'(done), 32'(cyc == busy_to + 1));
    chk("err_proto", 32'(err_proto), 32'(cyc >= err_from));
    if (sp_we) begin n_we++; sel_hist = {sel_hist[30:0], sp_sel}; end
    if (feed_en) begin n_feed++; feed_hist = {feed_hist[29:0], feed_layer}; end
    if (done) n_done++;
  endtask

  // One accepted input beat at cycle cyc, derived from its position in the job.
  task automatic beat_model();
    automatic int  p    = k % LB;
    automatic int  slot = (k / LB) % B;
    automatic int  s    = (cyc + 1) % 16;
    automatic bit  lastw = (p == LB - 1);
    automatic int  filled;
    if (!in_job) begin
      in_job = 1; busy_from = cyc + 1; busy_to = INF; uid_from = INF;
    end
    ew[s]   = 1'b1;
    esel[s] = (p >= A);
    ewrd[s] = (p >= A) ? WW'(p - A) : WW'(p);
    elyr[s] = LW'(slot);
    edat[s] = in_data;
    if (in_last && !lastw && err_from > cyc + 1) err_from = cyc + 1;
    k++;
    if (lastw && (in_last || slot == B - 1)) begin
      filled     = slot + 1;
      feed_from  = cyc + 2;
      feed_to    = cyc + 1 + filled;
      ready_from = cyc + filled + 1;
      if (in_last) begin
        post_load   = 1;
        wait_start  = cyc + filled + 1;
        uid_from    = cyc + filled + 2;
        plan_active = 0;
        k = 0;
      end
    end
  endtask

  // Drive random inputs for this cycle and advance the model.
  task automatic drive();
    automatic bit loading = plan_active && (k < plan_beats);
    in_valid       = loading && ($urandom_range(99) >= gap_pct);
    in_data        = $urandom;
    in_last        = in_valid && ((k == plan_beats - 1) || (k == illegal_at));
    out_ready      = ($urandom_range(99) >= stall_pct);
    unit_calc_done = ($urandom_range(99) < cd_pct);
    if (out_valid && out_ready) begin
      n_ob++; idx_hist = {idx_hist[29:0], out_idx};
    end
    if (in_valid && exp_ready()) beat_model();
    if (draining && cyc >= drain_start && out_ready) begin
      obeats++;
      if (obeats == O) begin
        busy_to = cyc; post_load = 0; ready_from = cyc + 1;
        draining = 0; in_job = 0; obeats = 0;
      end
    end else if (post_load && !draining && cyc >= wait_start && unit_calc_done) begin
      draining = 1; drain_start = cyc + 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    check_cycle();
    drive();
  endtask

  // Asynchronous reset mid-cycle: outputs must clear at once.
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; unit_calc_done = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_wdata", sp_wdata, 32'h0);
    chk("rst_ctl", 32'({in_ready, sp_we, sp_sel, sp_layer, sp_word, feed_en, feed_layer,
                        unit_in_done, out_valid, out_idx, done, busy, err_proto}), 32'h0);
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic start_plan(input int layers, input int ill, input int gap, input int stall,
                            input int cd);
    plan_beats = layers * LB; illegal_at = ill;
    gap_pct = gap; stall_pct = stall; cd_pct = cd;
    plan_active = 1;
    clear_obs();
  endtask

  task automatic run_job(input int layers, input int ill, input int gap, input int stall,
                         input int cd);
    automatic bit fin = 0;
    start_plan(layers, ill, gap, stall, cd);
    for (int i = 0; i < 3000 && !fin; i++) begin
      step();
      fin = !plan_active && !in_job && (cyc >= busy_to + 1);
    end
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL job_timeout layers=%0d actual=unfinished required=finished", layers);
      do_reset();
    end
  endtask

  initial begin
    @(posedge clk);
    cyc++;
    #1;
    do_reset();

    // One layer, job ends on its last weight word.
    run_job(1, -1, 0, 0, 50);
    chk("j1_writes", 32'(n_we), 32'd6);
    chk("j1_sel_seq", sel_hist & 32'h3f, 32'h0f);
    chk("j1_feeds", 32'(n_feed), 32'd1);
    chk("j1_done", 32'(n_done), 32'd1);
    chk("j1_idx_seq", idx_hist & 32'hff, 32'h1b);

    // Four layers: full batch of three, reload layer 0, then a batch of one.
    run_job(4, -1, 0, 0, 50);
    chk("j2_writes", 32'(n_we), 32'd24);
    chk("j2_feeds", 32'(n_feed), 32'd4);
    chk("j2_feed_seq", feed_hist & 32'hff, 32'h18);
    chk("j2_done", 32'(n_done), 32'd1);

    // unit_calc_done held high throughout loading and feeding.
    run_job(2, -1, 10, 0, 100);
    chk("j3_writes", 32'(n_we), 32'd12);
    chk("j3_done", 32'(n_done), 32'd1);

    // Random gaps, sink stalls and stray calc-done pulses.
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(7, 1), -1, 30, 40, 15);
      chk("rnd_done", 32'(n_done), 32'd1);
      chk("rnd_outs", 32'(n_ob), 32'd4);
      chk("rnd_idx_seq", idx_hist & 32'hff, 32'h1b);
    end

    // in_last on activation word 1: flag sticks, job completes normally.
    run_job(2, 1, 20, 20, 30);
    chk("err_writes", 32'(n_we), 32'd12);
    chk("err_sticky", 32'(err_proto), 32'd1);

    // Reset while feeding a full batch, then a clean job.
    start_plan(3, -1, 0, 0, 0);
    begin
      automatic bit hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
        step();
        hit = (cyc == feed_from);
      end
      chk("reach_feed", 32'(hit), 32'd1);
      chk("in_feed", 32'(feed_en), 32'd1);
    end
    do_reset();
    run_job(2, -1, 10, 10, 30);
    chk("post_rst_writes", 32'(n_we), 32'd12);
    chk("post_rst_err", 32'(err_proto), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
